// File: rtl/pipe_hazard_ctl_pkg.sv
// pipe_hazard_ctl_pkg
// Shared definitions for the pipeline hazard controller: the controller
// state encoding and the register-index width used by the hazard ports.
// No ports (package).
package pipe_hazard_ctl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctl_hazard_detect.sv
// hazard_detect
// Purely combinational load-use comparator. Flags when the load sitting in
// ID/EX writes a register that the instruction in IF/ID reads. Register 0 is
// hard-wired zero, so a load targeting it never creates a dependency.
// Ports:
//   mem_read  in   ID/EX instruction is a load
//   ex_rt     in   load destination register
//   rs, rt    in   IF/ID source registers
//   load_use  out  stall required this cycle
module hazard_detect
    import pipe_hazard_ctl_pkg::*;
(
    input  logic             mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    output logic             load_use
);

    assign load_use = mem_read && (ex_rt != '0) && ((ex_rt == rs) || (ex_rt == rt));

endmodule

// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl
// Pipeline hazard / stall controller for a 5-stage in-order pipeline.
// Handles load-use stalls, taken-branch flushes, multicycle EX ops and a
// debug halt that drains the pipeline before acknowledging.
// Optional build macro: HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   id_ex_mem_read, id_ex_rt   load in ID/EX and its destination
//   if_id_rs, if_id_rt         sources of the instruction in IF/ID
//   branch_taken               EX branch resolved taken
//   mc_start                   multicycle op entered EX
//   halt_req                   debug halt request (level)
//   pc_write, if_id_write      front-end advance enables
//   if_id_flush                zero IF/ID on next edge
//   id_ex_bubble               inject NOP control into ID/EX
//   ex_hold                    freeze ID/EX, bubble into EX/MEM
//   halt_ack                   pipeline drained and halted
//   stall_cycles, flush_cycles (HAZARD_PERF_CNT_EN only) event counters
module pipe_hazard_ctl
    import pipe_hazard_ctl_pkg::*;
#(
    parameter int MC_LAT    = 4,
    parameter int DRAIN_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             branch_taken,
    input  logic             mc_start,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_hold,
    output logic             halt_ack
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_cycles
`endif
);

    // Counters count down to 0 inclusive, hence the -2 / -1: the cycle of
    // entry into MC_BUSY is already the first hold cycle, giving MC_LAT-1 holds.
    localparam logic [3:0] MC_LOAD    = 4'(MC_LAT - 2);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_LEN - 1);

    hz_state_t  state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       load_use;

    hazard_detect u_hd (
        .mem_read (id_ex_mem_read),
        .ex_rt    (id_ex_rt),
        .rs       (if_id_rs),
        .rt       (if_id_rt),
        .load_use (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        halt_ack     = 1'b0;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    // Branch wins: wrong-path IF/ID is flushed, ID/EX bubbled,
                    // PC takes the target. Stall and mc_start are moot.
                    pc_write     = 1'b1;
                    if_id_write  = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else begin
                    if (load_use) begin
                        id_ex_bubble = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                    // A multicycle op outranks halt; halt stays pending (level)
                    // and is picked up on return to RUN.
                    if (mc_start) begin
                        state_n = MC_BUSY;
                        cnt_n   = MC_LOAD;
                    end else if (halt_req) begin
                        state_n = DRAIN;
                        cnt_n   = DRAIN_LOAD;
                    end
                end
            end
            MC_BUSY: begin
                ex_hold = 1'b1;
                if (cnt == 4'd0) state_n = RUN;
                else             cnt_n   = cnt - 4'd1;
            end
            DRAIN: begin
                id_ex_bubble = 1'b1;
                if (cnt == 4'd0) state_n = HALTED;
                else             cnt_n   = cnt - 4'd1;
            end
            HALTED: begin
                id_ex_bubble = 1'b1;
                halt_ack     = 1'b1;
                if (!halt_req) state_n = RUN;
            end
            default: state_n = RUN;
        endcase
        // Outputs are forced safe while reset is held, independent of clock.
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b1;
            ex_hold      = 1'b0;
            halt_ack     = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (!pc_write)   stall_cycles <= stall_cycles + 32'd1;
            if (if_id_flush) flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif

endmodule
